// File: rtl/capture_stream_ctrl.sv
// Capture control between board I/O and the camera pixel pipeline: key debounce to a
// stream reset pulse, whole-frame capture gating, completed-frame counter and heartbeat LED.
module capture_stream_ctrl #(
   parameter int DEBOUNCE_CYCLES  = 1000000,
   parameter int RST_PULSE_CYCLES = 16,
   parameter int LED_DIV          = 15,
   parameter int FRAME_CNT_W      = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   reset_stream_key,
   input  logic                   capture_en,
   input  logic                   frame_valid,
   output logic                   stream_reset,
   output logic                   capture_active,
   output logic                   pulse_led,
   output logic [FRAME_CNT_W-1:0] frame_count
);

   localparam int DEB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int PUL_W = (RST_PULSE_CYCLES > 1) ? $clog2(RST_PULSE_CYCLES) : 1;
   localparam int DIV_W = (LED_DIV > 1) ? $clog2(LED_DIV) : 1;

   localparam logic [DEB_W-1:0]       DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [PUL_W-1:0]       PUL_LAST = PUL_W'(RST_PULSE_CYCLES - 1);
   localparam logic [DIV_W-1:0]       DIV_LAST = DIV_W'(LED_DIV - 1);
   localparam logic [DEB_W-1:0]       DEB_ONE  = DEB_W'(1);
   localparam logic [PUL_W-1:0]       PUL_ONE  = PUL_W'(1);
   localparam logic [DIV_W-1:0]       DIV_ONE  = DIV_W'(1);
   localparam logic [FRAME_CNT_W-1:0] FC_ONE   = FRAME_CNT_W'(1);

   typedef enum logic [1:0] {IDLE, WAIT_SOF, CAPTURING, RST} state_t;

   state_t                 state_q, state_d;
   logic                   key_s1_q, key_s1_d, key_s2_q, key_s2_d;
   logic                   en_s1_q, en_s1_d, en_s2_q, en_s2_d;
   logic                   fval_d_q, fval_d_d;
   logic                   key_stable_q, key_stable_d;
   logic [DEB_W-1:0]       deb_cnt_q, deb_cnt_d;
   logic [PUL_W-1:0]       pul_cnt_q, pul_cnt_d;
   logic [DIV_W-1:0]       led_div_q, led_div_d;
   logic                   pulse_led_q, pulse_led_d;
   logic [FRAME_CNT_W-1:0] frame_count_q, frame_count_d;
   logic                   stream_reset_q, stream_reset_d;
   logic                   capture_active_q, capture_active_d;
   logic                   sof, eof, press;

   assign sof = frame_valid & ~fval_d_q;
   assign eof = ~frame_valid & fval_d_q;

   always_comb begin
      key_s1_d     = reset_stream_key;
      key_s2_d     = key_s1_q;
      en_s1_d      = capture_en;
      en_s2_d      = en_s1_q;
      fval_d_d     = frame_valid;
      key_stable_d = key_stable_q;
      deb_cnt_d    = '0;
      // Counter only runs while the synchronised key disagrees with the accepted level.
      if (key_s2_q != key_stable_q) begin
         if (deb_cnt_q == DEB_LAST) key_stable_d = key_s2_q;
         else                       deb_cnt_d    = deb_cnt_q + DEB_ONE;
      end
      press = key_stable_q & ~key_stable_d;
   end

   always_comb begin
      state_d       = state_q;
      pul_cnt_d     = pul_cnt_q;
      led_div_d     = led_div_q;
      pulse_led_d   = pulse_led_q;
      frame_count_d = frame_count_q;
      case (state_q)
         IDLE:      if (en_s2_q) state_d = WAIT_SOF;
         WAIT_SOF: begin
            if (!en_s2_q) state_d = IDLE;
            else if (sof) state_d = CAPTURING;
         end
         CAPTURING: if (eof) begin
            frame_count_d = frame_count_q + FC_ONE;
            if (led_div_q == DIV_LAST) begin
               led_div_d   = '0;
               pulse_led_d = ~pulse_led_q;
            end else begin
               led_div_d = led_div_q + DIV_ONE;
            end
            if (!en_s2_q) state_d = IDLE;
         end
         RST: begin
            if (pul_cnt_q == PUL_LAST) state_d   = IDLE;
            else                       pul_cnt_d = pul_cnt_q + PUL_ONE;
         end
         default:   state_d = IDLE;
      endcase
      // A press overrides everything, including a same-cycle EOF.
      if (press) begin
         state_d       = RST;
         pul_cnt_d     = '0;
         led_div_d     = '0;
         pulse_led_d   = 1'b0;
         frame_count_d = '0;
      end
      stream_reset_d   = (state_d == RST);
      capture_active_d = (state_d == CAPTURING);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q          <= IDLE;
         key_s1_q         <= 1'b1;
         key_s2_q         <= 1'b1;
         en_s1_q          <= 1'b0;
         en_s2_q          <= 1'b0;
         fval_d_q         <= 1'b0;
         key_stable_q     <= 1'b1;
         deb_cnt_q        <= '0;
         pul_cnt_q        <= '0;
         led_div_q        <= '0;
         pulse_led_q      <= 1'b0;
         frame_count_q    <= '0;
         stream_reset_q   <= 1'b0;
         capture_active_q <= 1'b0;
      end else begin
         state_q          <= state_d;
         key_s1_q         <= key_s1_d;
         key_s2_q         <= key_s2_d;
         en_s1_q          <= en_s1_d;
         en_s2_q          <= en_s2_d;
         fval_d_q         <= fval_d_d;
         key_stable_q     <= key_stable_d;
         deb_cnt_q        <= deb_cnt_d;
         pul_cnt_q        <= pul_cnt_d;
         led_div_q        <= led_div_d;
         pulse_led_q      <= pulse_led_d;
         frame_count_q    <= frame_count_d;
         stream_reset_q   <= stream_reset_d;
         capture_active_q <= capture_active_d;
      end
   end

   assign stream_reset   = stream_reset_q;
   assign capture_active = capture_active_q;
   assign pulse_led      = pulse_led_q;
   assign frame_count    = frame_count_q;

endmodule
